life_gen_scheduler: RTL and testbench

- Sequences Game of Life generation updates against the VGA frame timing.
- Decides when the cell-update engine starts, and swaps the display/work frame buffers only at frame start, so the display never tears.
- Sits between the VGA timing generator (consumes its vsync), the update engine (start/done handshake) and the framebuffer address muxes (buffer select).
- Supports free-run at a programmable frame rate and single-step.

---
 rtl/life_gen_scheduler.sv | 144 ++++++++++++++
 tb/tb_life_gen_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_scheduler.sv
// Game of Life generation scheduler: launches the update engine on VGA frame
// ticks and swaps display/work buffers only at frame start.
module life_gen_scheduler #(
   parameter int FRAMES_PER_GEN = 4,
   parameter int GEN_W          = 16
) (
   input  logic             clk_36MHz,
   input  logic             rst_n,
   input  logic             vsync,
   input  logic             run,
   input  logic             step,
   input  logic             clr,
   input  logic             eng_done,
   output logic             eng_start,
   output logic             disp_buf,
   output logic             work_buf,
   output logic             busy,
   output logic [GEN_W-1:0] generation,
   output logic             overrun
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPUTE   = 2'd1,
      SWAP_WAIT = 2'd2
   } state_t;

   localparam logic [8:0] PERIOD = 9'(FRAMES_PER_GEN);

   state_t     state;
   logic       vsync_q;
   logic       armed;
   logic       frame_tick;
   logic       step_pending;
   logic [7:0] frame_cnt;
   logic [8:0] frame_cnt_inc;
   logic       launch;
   logic       swap;
   logic       ovr_set;

   // armed masks the first sample after reset so a low vsync at release is not an edge
   assign frame_tick    = armed & vsync_q & ~vsync;
   assign frame_cnt_inc = {1'b0, frame_cnt} + 9'd1;

   assign launch  = (state == IDLE) && frame_tick &&
                    (step_pending || (run && (frame_cnt_inc >= PERIOD)));
   assign swap    = frame_tick &&
                    (((state == COMPUTE) && eng_done) || (state == SWAP_WAIT));
   assign ovr_set = (state == COMPUTE) && frame_tick && !eng_done;

   assign work_buf = ~disp_buf;

   always_ff @(posedge clk_36MHz or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         armed   <= 1'b0;
      end else begin
         vsync_q <= vsync;
         armed   <= 1'b1;
      end
   end

   always_ff @(posedge clk_36MHz or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 8'd0;
      end else if (launch) begin
         frame_cnt <= 8'd0;
      end else if (!run && (state == IDLE)) begin
         frame_cnt <= 8'd0;
      end else if (frame_tick && (frame_cnt != 8'd255)) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_36MHz or negedge rst_n) begin
      if (!rst_n) begin
         step_pending <= 1'b0;
      end else if (clr || launch) begin
         step_pending <= 1'b0;
      end else if (step) begin
         step_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk_36MHz or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         eng_start <= 1'b0;
         busy      <= 1'b0;
      end else begin
         eng_start <= launch;
         case (state)
            IDLE: begin
               if (launch) begin
                  state <= COMPUTE;
                  busy  <= 1'b1;
               end
            end
            COMPUTE: begin
               // done coinciding with the tick swaps at once rather than waiting a frame
               if (eng_done && frame_tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (eng_done) begin
                  state <= SWAP_WAIT;
               end
            end
            SWAP_WAIT: begin
               if (frame_tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_36MHz or negedge rst_n) begin
      if (!rst_n) begin
         disp_buf   <= 1'b0;
         generation <= '0;
         overrun    <= 1'b0;
      end else begin
         if (swap) begin
            disp_buf <= ~disp_buf;
         end
         if (clr) begin
            generation <= '0;
         end else if (swap) begin
            generation <= generation + GEN_W'(1);
         end
         if (clr) begin
            overrun <= 1'b0;
         end else if (ovr_set) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler: reset, free-run, single-step,
// overrun, simultaneous done/tick and FRAMES_PER_GEN=1 scenarios.
module tb_life_gen_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync = 1'b1;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        clr = 1'b0;
   logic        eng_done = 1'b0;

   logic        start_a, disp_a, work_a, busy_a, ovr_a;
   logic [15:0] gen_a;
   logic        start_b, disp_b, work_b, busy_b, ovr_b;
   logic [15:0] gen_b;

   logic        sel = 1'b0;
   logic        s_start, s_disp, s_work, s_busy, s_ovr;
   logic [15:0] s_gen;

   int errors = 0;
   int checks = 0;
   int eng_cnt = -1;
   int done_delay = 10;
   logic eng_auto = 1'b1;
   int starts = 0;
   int wide = 0;
   logic prev_start = 1'b0;

   always #14 clk = ~clk;

   life_gen_scheduler #(.FRAMES_PER_GEN(4), .GEN_W(16)) dut_a (
      .clk_36MHz(clk), .rst_n(rst_n), .vsync(vsync), .run(run), .step(step),
      .clr(clr), .eng_done(eng_done), .eng_start(start_a), .disp_buf(disp_a),
      .work_buf(work_a), .busy(busy_a), .generation(gen_a), .overrun(ovr_a)
   );

   life_gen_scheduler #(.FRAMES_PER_GEN(1), .GEN_W(16)) dut_b (
      .clk_36MHz(clk), .rst_n(rst_n), .vsync(vsync), .run(run), .step(step),
      .clr(clr), .eng_done(eng_done), .eng_start(start_b), .disp_buf(disp_b),
      .work_buf(work_b), .busy(busy_b), .generation(gen_b), .overrun(ovr_b)
   );

   assign s_start = sel ? start_b : start_a;
   assign s_disp  = sel ? disp_b  : disp_a;
   assign s_work  = sel ? work_b  : work_a;
   assign s_busy  = sel ? busy_b  : busy_a;
   assign s_ovr   = sel ? ovr_b   : ovr_a;
   assign s_gen   = sel ? gen_b   : gen_a;

   // one clock, then engine model and start-pulse monitor
   task automatic cycle();
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (s_start) begin
         starts++;
         if (prev_start) wide++;
         if (eng_auto) eng_cnt = done_delay;
      end else if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_done = 1'b1;
            eng_cnt  = -1;
         end
      end
      prev_start = s_start;
   endtask

   task automatic frame(input int len, output logic launched, output logic swapped);
      logic d0;
      d0 = s_disp;
      vsync = 1'b0;
      cycle();
      launched = s_start;
      swapped  = (s_disp !== d0);
      vsync = 1'b1;
      repeat (len - 1) cycle();
   endtask

   task automatic pulse_step();
      step = 1'b1;
      cycle();
      step = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      run = 1'b1;
      vsync = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vsync = ~vsync;
         cycle();
      end
      checks++; if (s_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", s_start); end
      checks++; if (s_disp !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b want 0", s_disp); end
      checks++; if (s_work !== 1'b1) begin errors++; $display("FAIL reset_work: got %b want 1", s_work); end
      checks++; if (s_gen !== 16'd0) begin errors++; $display("FAIL reset_gen: got %0d want 0", s_gen); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", s_busy); end
      checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", s_ovr); end
      vsync = 1'b0;
      rst_n = 1'b1;
      cycle();
      cycle();
      checks++; if (s_start !== 1'b0) begin errors++; $display("FAIL release_no_tick: got %b want 0", s_start); end
      vsync = 1'b1;
      repeat (5) cycle();
   endtask

   // run=1 since reset: a spurious release tick would shift launches one frame early
   task automatic test_free_run();
      logic l, s;
      int s0;
      done_delay = 1000;
      eng_auto = 1'b1;
      s0 = starts;
      for (int k = 1; k <= 13; k++) begin
         frame(1100, l, s);
         checks++;
         if (l !== ((k == 4) || (k == 8) || (k == 12))) begin
            errors++; $display("FAIL free_launch tick%0d: got %b", k, l);
         end
         checks++;
         if (s !== ((k == 5) || (k == 9) || (k == 13))) begin
            errors++; $display("FAIL free_swap tick%0d: got %b", k, s);
         end
         if (k == 4) begin
            checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL free_busy: got %b want 1", s_busy); end
         end
         if (k == 5) begin
            checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL free_idle: got %b want 0", s_busy); end
         end
      end
      checks++; if (s_gen !== 16'd3) begin errors++; $display("FAIL free_gen: got %0d want 3", s_gen); end
      checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL free_ovr: got %b want 0", s_ovr); end
      checks++; if (starts - s0 !== 3) begin errors++; $display("FAIL free_starts: got %0d want 3", starts - s0); end
      checks++; if (wide !== 0) begin errors++; $display("FAIL start_width: got %0d wide pulses want 0", wide); end
      checks++; if (s_disp !== 1'b1) begin errors++; $display("FAIL free_disp: got %b want 1", s_disp); end
      checks++; if (s_work !== ~s_disp) begin errors++; $display("FAIL free_work: got %b want %b", s_work, ~s_disp); end
   endtask

   task automatic test_single_step();
      logic l, s;
      int s0;
      run = 1'b0;
      done_delay = 20;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      cycle();
      checks++; if (s_gen !== 16'd0) begin errors++; $display("FAIL step_clr_gen: got %0d want 0", s_gen); end
      for (int i = 0; i < 3; i++) pulse_step();
      s0 = starts;
      for (int k = 1; k <= 10; k++) begin
         frame(60, l, s);
         checks++; if (l !== (k == 1)) begin errors++; $display("FAIL step_launch tick%0d: got %b", k, l); end
         checks++; if (s !== (k == 2)) begin errors++; $display("FAIL step_swap tick%0d: got %b", k, s); end
      end
      checks++; if (s_gen !== 16'd1) begin errors++; $display("FAIL step_gen: got %0d want 1", s_gen); end
      checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL step_starts: got %0d want 1", starts - s0); end
   endtask

   task automatic test_overrun();
      logic l, s, d;
      done_delay = 90;
      pulse_step();
      frame(60, l, s);
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL ovr_launch: got %b want 1", l); end
      vsync = 1'b0;
      cycle();
      checks++; if (s_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", s_ovr); end
      checks++; if (s_gen !== 16'd1) begin errors++; $display("FAIL ovr_noswap_gen: got %0d want 1", s_gen); end
      vsync = 1'b1;
      repeat (59) cycle();
      checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL ovr_busy: got %b want 1", s_busy); end
      frame(60, l, s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL ovr_swap: got %b want 1", s); end
      checks++; if (l !== 1'b0) begin errors++; $display("FAIL ovr_nolaunch: got %b want 0", l); end
      checks++; if (s_gen !== 16'd2) begin errors++; $display("FAIL ovr_gen: got %0d want 2", s_gen); end
      checks++; if (s_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", s_ovr); end
      d = s_disp;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %b want 0", s_ovr); end
      checks++; if (s_gen !== 16'd0) begin errors++; $display("FAIL clr_gen: got %0d want 0", s_gen); end
      checks++; if (s_disp !== d) begin errors++; $display("FAIL clr_disp: got %b want %b", s_disp, d); end
      repeat (5) cycle();
   endtask

   task automatic test_simultaneous();
      logic l, s, d;
      eng_auto = 1'b0;
      pulse_step();
      frame(40, l, s);
      checks++; if (l !== 1'b1) begin errors++; $display("FAIL sim_launch: got %b want 1", l); end
      pulse_step();
      d = s_disp;
      vsync = 1'b0;
      eng_done = 1'b1;
      cycle();
      checks++; if (s_disp !== ~d) begin errors++; $display("FAIL sim_swap: got %b want %b", s_disp, ~d); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", s_busy); end
      checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL sim_ovr: got %b want 0", s_ovr); end
      checks++; if (s_start !== 1'b0) begin errors++; $display("FAIL sim_nolaunch: got %b want 0", s_start); end
      checks++; if (s_gen !== 16'd1) begin errors++; $display("FAIL sim_gen: got %0d want 1", s_gen); end
      vsync = 1'b1;
      repeat (20) cycle();
      eng_auto = 1'b1;
      done_delay = 10;
      for (int k = 1; k <= 4; k++) begin
         frame(40, l, s);
         checks++; if (l !== (k == 1)) begin errors++; $display("FAIL busy_step_launch tick%0d: got %b", k, l); end
         checks++; if (s !== (k == 2)) begin errors++; $display("FAIL busy_step_swap tick%0d: got %b", k, s); end
      end
      checks++; if (s_gen !== 16'd2) begin errors++; $display("FAIL busy_step_gen: got %0d want 2", s_gen); end
   endtask

   task automatic test_fpg1();
      logic l, s;
      int s0;
      sel = 1'b1;
      eng_auto = 1'b1;
      done_delay = 10;
      rst_n = 1'b0;
      vsync = 1'b1;
      run = 1'b1;
      repeat (3) cycle();
      eng_cnt = -1;
      prev_start = 1'b0;
      rst_n = 1'b1;
      repeat (3) cycle();
      checks++; if (s_gen !== 16'd0) begin errors++; $display("FAIL fpg1_reset_gen: got %0d want 0", s_gen); end
      s0 = starts;
      for (int k = 1; k <= 6; k++) begin
         frame(40, l, s);
         checks++; if (l !== (k % 2 == 1)) begin errors++; $display("FAIL fpg1_launch tick%0d: got %b", k, l); end
         checks++; if (s !== (k % 2 == 0)) begin errors++; $display("FAIL fpg1_swap tick%0d: got %b", k, s); end
      end
      checks++; if (s_gen !== 16'd3) begin errors++; $display("FAIL fpg1_gen: got %0d want 3", s_gen); end
      checks++; if (starts - s0 !== 3) begin errors++; $display("FAIL fpg1_starts: got %0d want 3", starts - s0); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_single_step();
      test_overrun();
      test_simultaneous();
      test_fpg1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #(28 * 90000);
      $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
